// File: rtl/pulse_shrinker_pkg.sv
// Shared types and constants for the pulse shrinker and its input synchronizer.
package pulse_shrinker_pkg;

    localparam int c_sync_stages = 2;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_PRESS_CHK     = 3'd1,
        ST_PULSE         = 3'd2,
        ST_HELD          = 3'd3,
        ST_RELEASE_CHK   = 3'd4,
        ST_RELEASE_PULSE = 3'd5
    } t_shrink_state;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset; used for raw switch/button inputs.
module sync_2ff
    import pulse_shrinker_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [c_sync_stages-1:0] s_ff;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            s_ff <= '0;
        else
            s_ff <= {s_ff[c_sync_stages-2:0], i_d};
    end

    assign o_q = s_ff[c_sync_stages-1];

endmodule

// File: rtl/pulse_shrinker_synch.sv
// Debounces a bouncing async level into one single-cycle strobe per press.
// Optional release strobe (o_release) enabled by PULSE_SHRINKER_RELEASE_PULSE_EN.
//
// state            | meaning
// ST_IDLE          | released, waiting for x_s=1
// ST_PRESS_CHK     | x_s high, waiting for it to stay stable T cycles
// ST_PULSE         | press accepted, o_y high for one cycle
// ST_HELD          | pressed, waiting for x_s=0
// ST_RELEASE_CHK   | x_s low, waiting for it to stay stable T cycles
// ST_RELEASE_PULSE | release accepted, o_release high for one cycle (macro builds only)
module pulse_shrinker_synch
    import pulse_shrinker_pkg::*;
#(
    parameter int par_T_debounce_bits = 20,
    parameter int par_T_debounce_val  = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_x,
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
    output logic o_release,
`endif
    output logic o_y,
    output logic o_level
);

    localparam logic [par_T_debounce_bits-1:0] c_t_max =
        par_T_debounce_bits'(par_T_debounce_val - 1);

    logic                           x_s;
    logic [par_T_debounce_bits-1:0] s_t;
    t_shrink_state                  pr_state;
    t_shrink_state                  nx_state;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_x),
        .o_q   (x_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            pr_state <= ST_IDLE;
        else
            pr_state <= nx_state;
    end

    // Timer restarts on every state change and saturates so a long hold cannot wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            s_t <= '0;
        else if (pr_state != nx_state)
            s_t <= '0;
        else if (s_t < c_t_max)
            s_t <= s_t + par_T_debounce_bits'(1);
    end

    always_comb begin
        nx_state = pr_state;
        case (pr_state)
            ST_IDLE:
                if (x_s) nx_state = ST_PRESS_CHK;
            ST_PRESS_CHK:
                if (!x_s)                nx_state = ST_IDLE;
                else if (s_t >= c_t_max) nx_state = ST_PULSE;
            ST_PULSE:
                nx_state = ST_HELD;
            ST_HELD:
                if (!x_s) nx_state = ST_RELEASE_CHK;
            ST_RELEASE_CHK:
                if (x_s)                 nx_state = ST_HELD;
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
                else if (s_t >= c_t_max) nx_state = ST_RELEASE_PULSE;
            ST_RELEASE_PULSE:
                nx_state = ST_IDLE;
`else
                else if (s_t >= c_t_max) nx_state = ST_IDLE;
`endif
            default:
                nx_state = ST_IDLE;
        endcase
    end

    assign o_y     = (pr_state == ST_PULSE);
    assign o_level = (pr_state == ST_PULSE) || (pr_state == ST_HELD) ||
                     (pr_state == ST_RELEASE_CHK);
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
    assign o_release = (pr_state == ST_RELEASE_PULSE);
`endif

endmodule

// File: tb/tb_pulse_shrinker_synch.sv
// Self-checking bench: directed press/bounce/reset scenarios plus random levels against a run-length model.
module tb_pulse_shrinker_synch;

    localparam int T = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_x   = 1'b0;
    logic o_y;
    logic o_level;
    logic o_rel_obs;
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
    logic o_release;
    assign o_rel_obs = o_release;
`else
    assign o_rel_obs = 1'b0;
`endif

    pulse_shrinker_synch #(
        .par_T_debounce_bits (4),
        .par_T_debounce_val  (T)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_x       (i_x),
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
        .o_release (o_release),
`endif
        .o_y       (o_y),
        .o_level   (o_level)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model: the synchronized level is i_x delayed two edges; the debounced level
    // flips after T+1 consecutive opposite samples, and the strobe cycle that
    // follows an accepted change ignores its sample.
    logic m_s1, m_s2, m_level, m_skip, m_y, m_rel;
    int   m_run;

    int edge_n      = 0;
    int y_count     = 0;
    int last_y_edge = -1;
    int min_space   = 1000000;
    int fall_edge   = -1;
    int rel_edge    = -1;
    int lvl_hi      = 0;
    int lvl_lo      = 0;
    logic prev_level = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic x, input logic r);
        logic xs;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_skip = 0; m_y = 0; m_rel = 0; m_run = 0;
        end else begin
            xs    = m_s2;
            m_y   = 0;
            m_rel = 0;
            if (m_skip) begin
                m_skip = 0;
                m_run  = 0;
            end else if (xs != m_level) begin
                m_run++;
                if (m_run == T + 1) begin
                    m_run   = 0;
                    m_level = xs;
                    if (xs) begin
                        m_y    = 1;
                        m_skip = 1;
                    end else begin
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
                        m_rel  = 1;
                        m_skip = 1;
`endif
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = x;
        end
    endtask

    task automatic cycle(input logic x, input logic r);
        i_x   = x;
        i_rst = r;
        @(posedge i_clk);
        edge_n++;
        model_edge(x, r);
        #1;
        chk("o_y", int'(o_y), int'(m_y));
        chk("o_level", int'(o_level), int'(m_level));
        chk("o_release", int'(o_rel_obs), int'(m_rel));
        if (o_y === 1'b1) begin
            if (last_y_edge >= 0 && edge_n - last_y_edge < min_space)
                min_space = edge_n - last_y_edge;
            y_count++;
            last_y_edge = edge_n;
        end
        if (o_rel_obs === 1'b1) rel_edge = edge_n;
        if (prev_level && !o_level) fall_edge = edge_n;
        if (o_level === 1'b1) lvl_hi++; else lvl_lo++;
        prev_level = o_level;
    endtask

    initial begin
        int s, d, y0, len;
        logic xv;
        model_edge(1'b0, 1'b1);

        repeat (3) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);

        // Clean press and release
        y0 = y_count; s = edge_n + 1;
        repeat (20) cycle(1'b1, 1'b0);
        chk("press_pulses", y_count - y0, 1);
        chk("press_latency", last_y_edge - s, T + 2);
        d = edge_n + 1;
        repeat (12) cycle(1'b0, 1'b0);
        chk("level_fall", fall_edge - d, T + 2);
`ifdef PULSE_SHRINKER_RELEASE_PULSE_EN
        chk("release_latency", rel_edge - d, T + 2);
`endif

        // Bouncing press, 3 high / 1 low
        y0 = y_count; lvl_hi = 0;
        repeat (10) begin
            repeat (3) cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        repeat (8) cycle(1'b0, 1'b0);
        chk("bounce_press_pulses", y_count - y0, 0);
        chk("bounce_press_level", lvl_hi, 0);

        // Bouncing release
        y0 = y_count;
        repeat (10) cycle(1'b1, 1'b0);
        lvl_lo = 0;
        repeat (10) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        chk("bounce_release_pulses", y_count - y0, 1);
        chk("bounce_release_level", lvl_lo, 0);
        repeat (10) cycle(1'b0, 1'b0);

        // Reset in the middle of the press check with i_x held high
        repeat (3) cycle(1'b1, 1'b0);
        y0 = y_count; lvl_hi = 0;
        repeat (3) cycle(1'b1, 1'b1);
        chk("reset_no_pulse", y_count - y0, 0);
        chk("reset_level", lvl_hi, 0);
        s = edge_n + 1;
        repeat (12) cycle(1'b1, 1'b0);
        chk("post_reset_pulses", y_count - y0, 1);
        chk("post_reset_latency", last_y_edge - s, T + 2);
        repeat (10) cycle(1'b0, 1'b0);

        // Back-to-back presses, 8 high / 8 low
        y0 = y_count; last_y_edge = -1; min_space = 1000000;
        repeat (3) begin
            repeat (8) cycle(1'b1, 1'b0);
            repeat (8) cycle(1'b0, 1'b0);
        end
        chk("b2b_pulses", y_count - y0, 3);
        chk("b2b_spacing_ok", int'(min_space >= 2 * T + 2), 1);

        // Random levels with random run lengths and occasional resets
        repeat (150) begin
            xv  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0)
                repeat (2) cycle(xv, 1'b1);
            repeat (len) cycle(xv, 1'b0);
        end

        repeat (2) cycle(1'b1, 1'b1);
        chk("final_reset_y", int'(o_y), 0);
        chk("final_reset_level", int'(o_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
